// File: rtl/fir_channel_arbiter_if.sv
// rtl/fir_channel_arbiter_if.sv - Channel, FIR and result handshake bundle for fir_channel_arbiter
interface fir_channel_arbiter_if #(
    parameter int DATA_WIDTH = 24,
    parameter int CHANNELS   = 4,
    parameter int TAG_DEPTH  = 16
);
    localparam int CH_W  = $clog2(CHANNELS);
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    logic [CHANNELS*DATA_WIDTH-1:0] iv_ch_din;
    logic [CHANNELS-1:0]            iv_ch_din_valid;
    logic [CHANNELS-1:0]            ov_ch_ready;
    logic [DATA_WIDTH-1:0]          ov_fir_din;
    logic                           o_fir_din_valid;
    logic                           i_fir_ready;
    logic [DATA_WIDTH-1:0]          iv_fir_dout;
    logic                           i_fir_dout_valid;
    logic                           o_fir_ready;
    logic [DATA_WIDTH-1:0]          ov_dout;
    logic [CH_W-1:0]                ov_dout_ch;
    logic                           o_dout_valid;
    logic                           i_ready;
    logic [CNT_W-1:0]               ov_inflight;
    logic                           o_tag_err;

    // master: channel sources, FIR and downstream sink; slave: the arbiter
    modport master (
        output iv_ch_din, iv_ch_din_valid, i_fir_ready, iv_fir_dout, i_fir_dout_valid, i_ready,
        input  ov_ch_ready, ov_fir_din, o_fir_din_valid, o_fir_ready, ov_dout, ov_dout_ch,
               o_dout_valid, ov_inflight, o_tag_err
    );

    modport slave (
        input  iv_ch_din, iv_ch_din_valid, i_fir_ready, iv_fir_dout, i_fir_dout_valid, i_ready,
        output ov_ch_ready, ov_fir_din, o_fir_din_valid, o_fir_ready, ov_dout, ov_dout_ch,
               o_dout_valid, ov_inflight, o_tag_err
    );
endinterface

// File: rtl/fir_channel_arbiter.sv
// rtl/fir_channel_arbiter.sv - Round-robin FIR time-sharing arbiter with channel tag FIFO
module fir_channel_arbiter #(
    parameter int DATA_WIDTH = 24,
    parameter int CHANNELS   = 4,
    parameter int TAG_DEPTH  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    fir_channel_arbiter_if.slave bus
);
    localparam int CH_W = $clog2(CHANNELS);
    localparam int AW   = $clog2(TAG_DEPTH);
    localparam logic [AW:0]     FULL    = (AW+1)'(TAG_DEPTH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    logic [DATA_WIDTH-1:0] ch_word [CHANNELS];
    logic [CH_W-1:0]       rr_ptr;
    logic [CH_W-1:0]       grant;
    logic [CH_W-1:0]       idx;
    logic                  any_valid;
    logic                  can_issue;
    logic                  accept;

    logic [DATA_WIDTH-1:0] fir_din;
    logic                  fir_din_valid;
    logic [DATA_WIDTH-1:0] dout;
    logic [CH_W-1:0]       dout_ch;
    logic                  dout_valid;
    logic                  tag_err;
    logic                  fir_ready;
    logic                  fir_take;
    logic                  tag_pop;

    logic [CH_W-1:0]       tag_mem [TAG_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        assign ch_word[k] = bus.iv_ch_din[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan offsets high to low so the lowest offset from rr_ptr wins.
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            idx = CH_W'((int'(rr_ptr) + i) % CHANNELS);
            if (bus.iv_ch_din_valid[idx]) begin
                grant     = idx;
                any_valid = 1'b1;
            end
        end
    end

    // Occupancy is taken before any same-cycle pop, so a full FIFO blocks issue.
    assign can_issue = i_en & (~fir_din_valid | bus.i_fir_ready) & (count < FULL);
    assign accept    = can_issue & any_valid;

    assign fir_ready = i_en & (~dout_valid | bus.i_ready);
    assign fir_take  = bus.i_fir_dout_valid & fir_ready;
    assign tag_pop   = fir_take & (count != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rr_ptr        <= '0;
            fir_din       <= '0;
            fir_din_valid <= 1'b0;
            dout          <= '0;
            dout_ch       <= '0;
            dout_valid    <= 1'b0;
            tag_err       <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem[i] <= '0;
            end
        end else if (i_en) begin
            if (accept) begin
                fir_din         <= ch_word[grant];
                fir_din_valid   <= 1'b1;
                rr_ptr          <= (grant == LAST_CH) ? '0 : grant + 1'b1;
                tag_mem[wr_ptr] <= grant;
                wr_ptr          <= wr_ptr + 1'b1;
            end else if (bus.i_fir_ready) begin
                fir_din_valid <= 1'b0;
            end

            if (tag_pop) begin
                dout       <= bus.iv_fir_dout;
                dout_ch    <= tag_mem[rd_ptr];
                dout_valid <= 1'b1;
                rd_ptr     <= rd_ptr + 1'b1;
            end else if (bus.i_ready) begin
                dout_valid <= 1'b0;
            end

            // A result with no outstanding tag cannot be labelled; drop it and flag.
            if (fir_take && (count == '0)) begin
                tag_err <= 1'b1;
            end

            count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, tag_pop};
        end
    end

    assign bus.ov_ch_ready     = accept ? (CHANNELS'(1) << grant) : '0;
    assign bus.ov_fir_din      = fir_din;
    assign bus.o_fir_din_valid = fir_din_valid;
    assign bus.o_fir_ready     = fir_ready;
    assign bus.ov_dout         = dout;
    assign bus.ov_dout_ch      = dout_ch;
    assign bus.o_dout_valid    = dout_valid;
    assign bus.ov_inflight     = count;
    assign bus.o_tag_err       = tag_err;
endmodule

// File: doc/fir_channel_arbiter.md
Name: fir_channel_arbiter

Overview:
- Time-shares one FIR filter datapath between CHANNELS independent parallel-word sample streams, such as several deserializer outputs.
- Selects input channels round-robin and forwards accepted samples to the FIR input handshake.
- Records each accepted sample's channel ID in a tag FIFO, and pairs every FIR output with the head tag so results return labelled with their source channel.
- Sits between per-channel deserializers and the FIR, and between the FIR and a channel-aware serializer/demux.

Parameters:
- DATA_WIDTH, 24, sample width in bits.
- CHANNELS, 4, number of requesting channels (2..16).
- TAG_DEPTH, 16, maximum samples in flight inside the FIR (power of 2); tag FIFO depth.
- CH_W, $clog2(CHANNELS), localparam, channel ID width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous reset, active-low.
- i_en  in  1  global enable; when low, all state freezes.
- iv_ch_din  in  CHANNELS*DATA_WIDTH  channel samples; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- iv_ch_din_valid  in  CHANNELS  per-channel valid.
- ov_ch_ready  out  CHANNELS  per-channel ready, at most one bit high.
- ov_fir_din  out  DATA_WIDTH  sample to FIR.
- o_fir_din_valid  out  1  FIR input valid.
- i_fir_ready  in  1  FIR accepts input.
- iv_fir_dout  in  DATA_WIDTH  FIR result.
- i_fir_dout_valid  in  1  FIR result valid.
- o_fir_ready  out  1  arbiter accepts FIR result.
- ov_dout  out  DATA_WIDTH  labelled result.
- ov_dout_ch  out  CH_W  source channel of ov_dout.
- o_dout_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- ov_inflight  out  $clog2(TAG_DEPTH)+1  tag FIFO occupancy.
- o_tag_err  out  1  sticky error: FIR produced a result with no tag outstanding.

Behaviour:
- Reset (i_rst=0 at a clock edge): every register clears.
  - o_fir_din_valid=0, o_dout_valid=0, ov_fir_din=0, ov_dout=0, ov_dout_ch=0.
  - Round-robin pointer=0, tag FIFO empty, ov_inflight=0, o_tag_err=0.
  - Reset mid-operation discards in-flight tags. The FIR must be reset in the same cycle.
- Enable: i_en=0 forces ov_ch_ready=0 and o_fir_ready=0; all registers hold.
- Grant (combinational): the first k with iv_ch_din_valid[k]=1, searching from pointer upward and wrapping modulo CHANNELS.
- Issue condition: can_issue = i_en & (~o_fir_din_valid | i_fir_ready) & (ov_inflight < TAG_DEPTH).
  - ov_ch_ready = one-hot(grant) when can_issue and any channel is valid, else 0.
  - Ready must not depend on that channel's own valid beyond grant selection.
- Accept (valid & ready on channel g):
  - Next cycle, ov_fir_din = channel g data and o_fir_din_valid=1.
  - Push g into the tag FIFO.
  - Pointer becomes (g+1) mod CHANNELS.
  - Latency: accept at cycle N → o_fir_din_valid at N+1.
- FIR input register: holds its value until i_fir_ready=1; clears valid if no new accept in the same cycle.
- Tag-full boundary: occupancy is compared before any same-cycle pop. At ov_inflight=TAG_DEPTH, all readies are 0 even if a pop occurs that cycle.
- Return path: o_fir_ready = i_en & (~o_dout_valid | i_ready).
  - On i_fir_dout_valid & o_fir_ready, with FIFO non-empty: the next cycle shows ov_dout=iv_fir_dout, ov_dout_ch=head tag, o_dout_valid=1; pop the tag.
  - With FIFO empty (checked before any same-cycle push): drop the result, set o_tag_err=1 (sticky until reset), o_dout_valid unchanged.
- Output register: holds its value while o_dout_valid & ~i_ready; clears when taken with no new result.
- Simultaneous push and pop: both occur and ov_inflight is unchanged. The FIFO pointers wrap modulo TAG_DEPTH.
- Ordering: the FIR preserves order, so outputs leave in exactly the acceptance order.

Test Plan:
- Single channel with a pass-through FIR stub of latency 3: channel 2 sends 0x000001, 0x000002, 0x000003 → ov_dout gives the same values in order with ov_dout_ch=2; first o_fir_din_valid 1 cycle after accept.
- All 4 channels continuously valid, all readies high → grant sequence 0,1,2,3,0,1… with exactly one ov_ch_ready bit high per cycle and 1 sample accepted per cycle.
- Only channels 1 and 3 valid → grants alternate 1,3,1,3; after reset with only channel 3 valid, the first grant is 3.
- TAG_DEPTH=4 with the stub withholding outputs → exactly 4 accepts, then ov_inflight=4 and ov_ch_ready=0. Releasing one output → ov_inflight drops to 3 and one new accept follows on the next cycle.
- Backpressure cases:
  - i_ready=0 for 5 cycles → ov_dout/ov_dout_ch stable, o_fir_ready=0.
  - i_fir_ready=0 → ov_fir_din stable and no new grants.
  - i_en=0 mid-stream → all outputs frozen; stream resumes losslessly.
- Spurious FIR output with the FIFO empty → o_tag_err=1, no o_dout_valid. Asserting i_rst=0 mid-stream → all outputs 0 and ov_inflight=0 on the next cycle.
